hazard_scheduler: RTL
=====================

Name: hazard_scheduler

Overview:
- Pipeline hazard controller that sequences the fetch/decode front end of the 5-stage MIPS core.
- Decides each cycle whether PC and IF/ID advance, stall or flush, and whether ID/EX receives a bubble.
- Handles three cases: load-use hazards, JR operand hazards (JR reads the register file in ID with no forwarding path), and taken-branch squashes resolved in EX.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a taken branch (1..7)
CNT_W, 16, width of the performance counters

Ports:
Clk_in  input  1  core clock, rising edge
Rst_n  input  1  asynchronous active-low reset
rs_ID  input  5  Instruction_ID[25:21]
rt_ID  input  5  Instruction_ID[20:16]
uses_rs_ID  input  1  ID instruction reads rs
uses_rt_ID  input  1  ID instruction reads rt
JR_ID  input  1  ID instruction is JR
RegWrite_EX  input  1  EX-stage instruction writes a register
MemRead_EX  input  1  EX-stage instruction is a load
dest_EX  input  5  EX-stage destination register (after RegDst/JAL mux)
RegWrite_MEM  input  1  MEM-stage instruction writes a register
MemRead_MEM  input  1  MEM-stage instruction is a load
dest_MEM  input  5  MEM-stage destination register
branch_taken_EX  input  1  branch/jump in EX resolved taken this cycle
PCWrite_out  output  1  PC register load enable
IFIDWrite_out  output  1  IF/ID load enable
IFIDFlush_out  output  1  IF/ID loads a NOP
IDEXBubble_out  output  1  ID/EX control bits forced to 0
stall_cycles_out  output  CNT_W  saturating count of stalled cycles
flush_events_out  output  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Hazard conditions (combinational); register 0 never hazards:
  - lu = MemRead_EX & RegWrite_EX & dest_EX!=0 & ((uses_rs_ID & dest_EX==rs_ID) | (uses_rt_ID & dest_EX==rt_ID))
  - jrh = JR_ID & rs_ID!=0 & ((RegWrite_EX & dest_EX==rs_ID) | (RegWrite_MEM & dest_MEM==rs_ID))
- States: RUN, FLUSH, JR_WAIT. Reset state RUN, internal flush counter fcnt=0.
- Control outputs are combinational from state and inputs; same-cycle response, zero latency.
- Output encodings:
  - NORMAL: PCWrite=1, IFIDWrite=1, Flush=0, Bubble=0
  - STALL: PCWrite=0, IFIDWrite=0, Flush=0, Bubble=1
  - SQUASH: PCWrite=1, IFIDWrite=1, Flush=1, Bubble=1
- Priority, identical in every state: branch_taken_EX > (state FLUSH) > jrh > lu > normal. The branch is older than any ID instruction, so it always wins.
- RUN:
  - branch_taken_EX: SQUASH; go to FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay RUN.
  - jrh: STALL; go to JR_WAIT.
  - lu: STALL, one cycle only; stay RUN. Next cycle the load is in MEM and lu deasserts.
  - Otherwise NORMAL.
- FLUSH: SQUASH; decrement fcnt; go to RUN when fcnt==1. A branch_taken_EX in FLUSH reloads fcnt=FLUSH_CYCLES-1.
- JR_WAIT:
  - branch_taken_EX: SQUASH; go to FLUSH or RUN as in RUN.
  - jrh still true: STALL.
  - jrh false: NORMAL; go to RUN.
  - JR_ID dropping while in JR_WAIT returns to RUN.
- Counters:
  - stall_cycles_out increments on every cycle whose encoding is STALL.
  - flush_events_out increments on each cycle with branch_taken_EX=1.
  - Both saturate at all-ones; no wrap.
- Reset (Rst_n low), asynchronous and immediate: state RUN, fcnt=0, counters 0. Outputs forced to PCWrite=0, IFIDWrite=0, Flush=1, Bubble=1 for as long as Rst_n=0.
- Reset deasserted mid-stall or mid-flush resumes in RUN with NORMAL outputs.
- Simultaneous lu and jrh: treated as a JR stall (enters JR_WAIT).

Decomposition:
- Shared pipeline package holds:
  - state encoding constants (RUN=2'd0, FLUSH=2'd1, JR_WAIT=2'd2)
  - the NOP instruction constant 32'h0000_0000
  - register-0 constant
- One sub-module: hazard_sat_counter (CNT_W, inc, clear on reset, saturating). Instantiated twice.

Test Plan:
- lw $t0 in EX (MemRead_EX=1, RegWrite_EX=1, dest_EX=8) with add using rs=8 in ID -> exactly one cycle PCWrite=0/IFIDWrite=0/Bubble=1, then NORMAL; stall_cycles_out=1.
- Same load with dest_EX=0 and rs_ID=0 -> NORMAL throughout, counter stays 0.
- JR_ID=1, rs_ID=31, RegWrite_EX=1, dest_EX=31 for one cycle, then RegWrite_MEM=1, dest_MEM=31 for one cycle -> two STALL cycles, state JR_WAIT, third cycle NORMAL; stall_cycles_out=2.
- branch_taken_EX=1 concurrent with lu=1, FLUSH_CYCLES=1 -> SQUASH (Flush=1, Bubble=1, PCWrite=1), no stall counted; flush_events_out=1.
- FLUSH_CYCLES=3, branch_taken_EX pulse -> SQUASH for 3 consecutive cycles, then NORMAL; a second pulse in cycle 2 extends SQUASH through cycle 4.
- Drive Rst_n low mid-JR_WAIT -> outputs go to reset values immediately, counters 0; on release, NORMAL in RUN. Counter preloaded near max saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// Shared pipeline constants for the MIPS front-end hazard controller:
// FSM state encodings, NOP/register-0 constants and the control-output bundle.
package hazard_scheduler_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_JR_WAIT = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic flush;
    logic bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, flush: 1'b0, bubble: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, flush: 1'b0, bubble: 1'b1};
  localparam ctrl_t CTRL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1, flush: 1'b1, bubble: 1'b1};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, flush: 1'b1, bubble: 1'b1};

  function automatic logic reg_match(input logic en, input logic [4:0] dest, input logic [4:0] src);
    return en && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Hazard-information and pipeline-control bundle between the datapath (master)
// and the hazard scheduler (slave).
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             uses_rs_ID;
  logic             uses_rt_ID;
  logic             JR_ID;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic [4:0]       dest_EX;
  logic             RegWrite_MEM;
  logic             MemRead_MEM;
  logic [4:0]       dest_MEM;
  logic             branch_taken_EX;
  logic             PCWrite_out;
  logic             IFIDWrite_out;
  logic             IFIDFlush_out;
  logic             IDEXBubble_out;
  logic [CNT_W-1:0] stall_cycles_out;
  logic [CNT_W-1:0] flush_events_out;

  modport master (
    output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, JR_ID,
    output RegWrite_EX, MemRead_EX, dest_EX,
    output RegWrite_MEM, MemRead_MEM, dest_MEM, branch_taken_EX,
    input  PCWrite_out, IFIDWrite_out, IFIDFlush_out, IDEXBubble_out,
    input  stall_cycles_out, flush_events_out
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, JR_ID,
    input  RegWrite_EX, MemRead_EX, dest_EX,
    input  RegWrite_MEM, MemRead_MEM, dest_MEM, branch_taken_EX,
    output PCWrite_out, IFIDWrite_out, IFIDFlush_out, IDEXBubble_out,
    output stall_cycles_out, flush_events_out
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones,
// cleared asynchronously by reset.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Front-end hazard controller: load-use / JR-operand stalls and taken-branch squashes,
// zero-latency combinational control with saturating stall/flush counters.
import hazard_scheduler_pkg::*;

module hazard_scheduler #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic               Clk_in,
  input logic               Rst_n,
  hazard_scheduler_if.slave hz
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] fcnt;
  logic [2:0] fcnt_nxt;
  logic       lu;
  logic       jrh;
  logic       stall_evt;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  assign lu = hz.MemRead_EX && hz.RegWrite_EX && (hz.dest_EX != REG_ZERO) &&
              (reg_match(hz.uses_rs_ID, hz.dest_EX, hz.rs_ID) ||
               reg_match(hz.uses_rt_ID, hz.dest_EX, hz.rt_ID));

  // JR reads rs in ID with no forwarding, so any in-flight writer of rs blocks it.
  assign jrh = hz.JR_ID && (hz.rs_ID != REG_ZERO) &&
               (reg_match(hz.RegWrite_EX,  hz.dest_EX,  hz.rs_ID) ||
                reg_match(hz.RegWrite_MEM, hz.dest_MEM, hz.rs_ID));

  // One priority chain for every state; JR_WAIT only differs in where it returns.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    ctrl      = CTRL_NORMAL;
    stall_evt = 1'b0;
    if (hz.branch_taken_EX) begin
      ctrl = CTRL_SQUASH;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = ST_FLUSH;
        fcnt_nxt  = FLUSH_RELOAD;
      end else begin
        state_nxt = ST_RUN;
        fcnt_nxt  = 3'd0;
      end
    end else if (state == ST_FLUSH) begin
      ctrl     = CTRL_SQUASH;
      fcnt_nxt = fcnt - 3'd1;
      if (fcnt <= 3'd1) begin
        state_nxt = ST_RUN;
        fcnt_nxt  = 3'd0;
      end
    end else if (jrh) begin
      ctrl      = CTRL_STALL;
      stall_evt = 1'b1;
      state_nxt = ST_JR_WAIT;
    end else if (lu) begin
      ctrl      = CTRL_STALL;
      stall_evt = 1'b1;
      state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  assign ctrl_out          = Rst_n ? ctrl : CTRL_RESET;
  assign hz.PCWrite_out    = ctrl_out.pc_write;
  assign hz.IFIDWrite_out  = ctrl_out.ifid_write;
  assign hz.IFIDFlush_out  = ctrl_out.flush;
  assign hz.IDEXBubble_out = ctrl_out.bubble;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (Clk_in),
    .rst_n (Rst_n),
    .inc   (stall_evt),
    .count (hz.stall_cycles_out)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (Clk_in),
    .rst_n (Rst_n),
    .inc   (hz.branch_taken_EX),
    .count (hz.flush_events_out)
  );

endmodule
